// File: rtl/isqrt_pkg.sv
// Shared helpers for the pipelined integer square root: stage count,
// per-slice trial bit and the result widths derived from the operand width.
package isqrt_pkg;

  localparam int ISQRT_MAX_W     = 128;
  localparam int ISQRT_W_DEF     = 32;
  localparam int ISQRT_TAG_W_DEF = 8;

  function automatic int isqrt_root_w(input int w);
    return w / 2;
  endfunction

  function automatic int isqrt_rem_w(input int w);
    return w / 2 + 1;
  endfunction

  function automatic int isqrt_n_stages(input int w, input int s);
    return (w / 2 + s - 1) / s;
  endfunction

  // Trial bit for slice i; callers truncate to their operand width.
  function automatic logic [ISQRT_MAX_W-1:0] isqrt_m(input int w, input int i);
    logic [ISQRT_MAX_W-1:0] one;
    one = ISQRT_MAX_W'(1);
    return one << (w - 2 - 2 * i);
  endfunction

endpackage

// File: rtl/isqrt_pipe_stage.sv
// One register stage of the square-root pipeline: NSL combinational slices
// starting at slice FIRST, followed by the stage's valid/data/tag registers.
module isqrt_pipe_stage
  import isqrt_pkg::*;
#(
  parameter int W     = 32,
  parameter int TAG_W = 8,
  parameter int FIRST = 0,
  parameter int NSL   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [W-1:0]     up_x,
  input  logic [W-1:0]     up_y,
  input  logic [TAG_W-1:0] up_tag,
  input  logic             dn_load,
  output logic             vld,
  output logic [W-1:0]     x,
  output logic [W-1:0]     y,
  output logic [TAG_W-1:0] tag
);

  logic             vld_p0;
  logic [W-1:0]     x_p0;
  logic [W-1:0]     y_p0;
  logic [TAG_W-1:0] tag_p0;
  logic [W-1:0]     x_c;
  logic [W-1:0]     y_c;
  logic             load;

  function automatic logic [2*W-1:0] sqrt_slice(input logic [W-1:0] xi,
                                                input logic [W-1:0] yi,
                                                input logic [W-1:0] mi);
    logic [W-1:0] t;
    t = yi | mi;
    if (xi >= t) return {xi - t, (yi >> 1) | mi};
    return {xi, yi >> 1};
  endfunction

  always_comb begin
    x_c = up_x;
    y_c = up_y;
    for (int j = 0; j < NSL; j++)
      {x_c, y_c} = sqrt_slice(x_c, y_c, W'(isqrt_m(W, FIRST + j)));
  end

  // An empty stage always loads, so bubbles collapse behind a stall.
  assign load = !vld_p0 || dn_load;

  // ---- stage register boundary ----
  always_ff @(posedge clk) begin
    if (rst)       vld_p0 <= 1'b0;
    else if (load) vld_p0 <= up_valid;
  end

  always_ff @(posedge clk) begin
    if (load && up_valid) begin
      x_p0   <= x_c;
      y_p0   <= y_c;
      tag_p0 <= up_tag;
    end
  end

  assign vld = vld_p0;
  assign x   = x_p0;
  assign y   = y_p0;
  assign tag = tag_p0;

endmodule

// File: rtl/isqrt_pipe.sv
// Fully pipelined unsigned integer square root with valid/ready flow control,
// bubble collapsing, tag pass-through and remainder output.
module isqrt_pipe
  import isqrt_pkg::*;
#(
  parameter int W     = ISQRT_W_DEF,
  parameter int S     = 1,
  parameter int TAG_W = ISQRT_TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W/2-1:0]   out_root,
  output logic [W/2:0]     out_rem,
  output logic [TAG_W-1:0] out_tag
);

  localparam int ROOT_W = isqrt_root_w(W);
  localparam int REM_W  = isqrt_rem_w(W);
  localparam int N      = isqrt_n_stages(W, S);

  if (W < 2 || (W % 2) != 0) begin : g_bad_w
    $error("isqrt_pipe: W must be even and >= 2");
  end
  if (S < 1 || S > W / 2) begin : g_bad_s
    $error("isqrt_pipe: S must satisfy 1 <= S <= W/2");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("isqrt_pipe: TAG_W must be >= 1");
  end

  // Index 0 is the upstream port; index k+1 is the output of stage k.
  logic [N:0]       vld_c;
  logic [W-1:0]     x_c   [N+1];
  logic [W-1:0]     y_c   [N+1];
  logic [TAG_W-1:0] tag_c [N+1];
  logic [N-1:0]     dn_load;

  assign vld_c[0] = in_valid;
  assign x_c[0]   = in_x;
  assign y_c[0]   = '0;
  assign tag_c[0] = in_tag;

  // load_k = !vld[k] || load_{k+1} unrolled: a stage may advance when the
  // output is taken or any stage downstream of it is empty.
  assign in_ready = out_ready || !(&vld_c[N:1]);

  for (genvar k = 0; k < N; k++) begin : g_stage
    localparam int NSL_K = (k == N - 1) ? ROOT_W - (N - 1) * S : S;

    if (k == N - 1) begin : g_last
      assign dn_load[k] = out_ready;
    end else begin : g_mid
      assign dn_load[k] = out_ready || !(&vld_c[N:k+2]);
    end

    isqrt_pipe_stage #(
      .W     (W),
      .TAG_W (TAG_W),
      .FIRST (k * S),
      .NSL   (NSL_K)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (vld_c[k]),
      .up_x     (x_c[k]),
      .up_y     (y_c[k]),
      .up_tag   (tag_c[k]),
      .dn_load  (dn_load[k]),
      .vld      (vld_c[k+1]),
      .x        (x_c[k+1]),
      .y        (y_c[k+1]),
      .tag      (tag_c[k+1])
    );
  end

  assign out_valid = vld_c[N];
  assign out_root  = y_c[N][ROOT_W-1:0];
  assign out_rem   = x_c[N][REM_W-1:0];
  assign out_tag   = tag_c[N];

  always @(posedge clk) begin
    if (!rst && out_valid)
      assert (((x_c[N] >> REM_W) == '0) && ((y_c[N] >> ROOT_W) == '0))
        else $error("isqrt_pipe: non-zero discarded bits in final slice state");
  end

endmodule

// File: tb/tb_isqrt_pipe.sv
// Directed and streaming bench for isqrt_pipe: edge values, streaming,
// backpressure, bubble collapse, mid-flight reset and a parameter sweep.
module tb_isqrt_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // W=32, S=1 (16 stages)
  logic        v1 = 1'b0, r1, ov1, or1 = 1'b1;
  logic [31:0] x1 = '0;
  logic [7:0]  t1 = '0, ot1;
  logic [15:0] root1;
  logic [16:0] rem1;

  // W=32, S=4 (4 stages), wide tags for distinct stream tags
  logic        v4 = 1'b0, r4, ov4, or4 = 1'b1;
  logic [31:0] x4 = '0;
  logic [15:0] t4 = '0, ot4;
  logic [15:0] root4;
  logic [16:0] rem4;

  isqrt_pipe #(.W(32), .S(1), .TAG_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_x(x1), .in_tag(t1),
    .out_valid(ov1), .out_ready(or1), .out_root(root1), .out_rem(rem1), .out_tag(ot1));

  isqrt_pipe #(.W(32), .S(4), .TAG_W(16)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .in_x(x4), .in_tag(t4),
    .out_valid(ov4), .out_ready(or4), .out_root(root4), .out_rem(rem4), .out_tag(ot4));

  // Parameter sweep instances, all run concurrently once sw_start rises.
  localparam int NSW = 13;
  localparam int SW_W [NSW] = '{2, 8, 8, 8, 16, 16, 16, 32, 32, 32, 64, 64, 64};
  localparam int SW_S [NSW] = '{1, 1, 3, 4, 1, 3, 8, 1, 3, 16, 1, 3, 32};
  logic sw_start = 1'b0;
  int   sw_left  = NSW;

  for (genvar g = 0; g < NSW; g++) begin : g_sw
    localparam int GW  = SW_W[g];
    localparam int GS  = SW_S[g];
    localparam int GN  = (GW / 2 + GS - 1) / GS;
    localparam int CNT = (GW <= 16) ? (1 << GW) : 2000;

    logic          sv = 1'b0, sr, ov;
    logic [GW-1:0] sx = '0;
    logic [31:0]   st = '0, ot;
    logic [GW/2-1:0] oroot;
    logic [GW/2:0]   orem;
    logic [127:0]  xq [$];
    int            aq [$];

    isqrt_pipe #(.W(GW), .S(GS), .TAG_W(32)) u_dut (
      .clk(clk), .rst(rst), .in_valid(sv), .in_ready(sr), .in_x(sx), .in_tag(st),
      .out_valid(ov), .out_ready(1'b1), .out_root(oroot), .out_rem(orem), .out_tag(ot));

    initial begin
      logic [63:0] r64;
      wait (sw_start);
      for (int i = 0; i < CNT; i++) begin
        @(negedge clk);
        r64 = {$urandom, $urandom};
        sv = 1'b1;
        sx = (GW <= 16) ? GW'(i) : GW'(r64);
        st = 32'(i);
        #1;
        if (sr !== 1'b1) begin
          n_tests++; n_fail++;
          $display("FAIL sweep_in_ready W=%0d S=%0d: in_ready=%b required 1", GW, GS, sr);
        end
        xq.push_back(128'(sx));
        aq.push_back(cyc);
      end
      @(negedge clk);
      sv = 1'b0;
    end

    initial begin
      int got, guard, a;
      logic [127:0] xx, rr, mm;
      got = 0; guard = 0;
      wait (sw_start);
      while (got < CNT && guard < CNT + 200) begin
        @(negedge clk);
        guard++;
        if (ov === 1'b1 && xq.size() > 0) begin
          xx = xq.pop_front();
          a  = aq.pop_front();
          rr = 128'(oroot);
          mm = 128'(orem);
          n_tests++;
          if (!(rr * rr <= xx && xx < (rr + 1) * (rr + 1))) begin
            n_fail++;
            $display("FAIL sweep_root W=%0d S=%0d x=%0h: root=%0h", GW, GS, xx, rr);
          end
          n_tests++;
          if (mm !== xx - rr * rr) begin
            n_fail++;
            $display("FAIL sweep_rem W=%0d S=%0d x=%0h: rem=%0h required %0h", GW, GS, xx, mm, xx - rr * rr);
          end
          n_tests++;
          if (ot !== 32'(got)) begin
            n_fail++;
            $display("FAIL sweep_tag W=%0d S=%0d: tag=%0d required %0d", GW, GS, ot, got);
          end
          n_tests++;
          if (cyc !== a + GN) begin
            n_fail++;
            $display("FAIL sweep_latency W=%0d S=%0d: latency=%0d required %0d", GW, GS, cyc - a, GN);
          end
          got++;
        end
      end
      sw_left--;
    end
  end

  task automatic test_reset();
    rst = 1'b1; v1 = 1'b0; v4 = 1'b0; or1 = 1'b0; or4 = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (ov1 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_s1: got %b required 0", ov1); end
    n_tests++;
    if (r1 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_s1: got %b required 1", r1); end
    n_tests++;
    if (ov4 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_s4: got %b required 0", ov4); end
    n_tests++;
    if (r4 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_s4: got %b required 1", r4); end
    rst = 1'b0; or1 = 1'b1; or4 = 1'b1;
  endtask

  task automatic test_edge();
    logic [31:0] xv [4];
    logic [15:0] rv [4];
    logic [16:0] mv [4];
    int k;
    xv = '{32'd0, 32'd16, 32'd17, 32'hFFFF_FFFF};
    rv = '{16'd0, 16'd4, 16'd4, 16'd65535};
    mv = '{17'd0, 17'd0, 17'd1, 17'd131070};
    or1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v1 = 1'b1; x1 = xv[i]; t1 = 8'(8'h10 + i);
      #1;
      n_tests++;
      if (r1 !== 1'b1) begin n_fail++; $display("FAIL edge_in_ready[%0d]: got %b required 1", i, r1); end
      @(negedge clk);
      v1 = 1'b0;
      k = 1;
      while (ov1 !== 1'b1 && k < 40) begin @(negedge clk); k++; end
      n_tests++;
      if (k !== 16) begin n_fail++; $display("FAIL edge_latency[%0d]: got %0d required 16", i, k); end
      n_tests++;
      if (root1 !== rv[i]) begin n_fail++; $display("FAIL edge_root[%0d]: got %0d required %0d", i, root1, rv[i]); end
      n_tests++;
      if (rem1 !== mv[i]) begin n_fail++; $display("FAIL edge_rem[%0d]: got %0d required %0d", i, rem1, mv[i]); end
      n_tests++;
      if (ot1 !== 8'(8'h10 + i)) begin n_fail++; $display("FAIL edge_tag[%0d]: got %0h required %0h", i, ot1, 8'h10 + i); end
    end
  endtask

  task automatic test_stream();
    logic [31:0] xq [$];
    int aq [$];
    logic [127:0] xx, rr, mm;
    int got, guard, a;
    got = 0; guard = 0;
    or4 = 1'b1;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          v4 = 1'b1;
          x4 = (i == 0) ? 32'hFFFF_FFFF : (i == 1) ? 32'd0 : $urandom;
          t4 = 16'(i);
          #1;
          if (r4 !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL stream_in_ready[%0d]: got %b required 1", i, r4);
          end
          xq.push_back(x4);
          aq.push_back(cyc);
        end
        @(negedge clk);
        v4 = 1'b0;
      end
      begin
        while (got < 1000 && guard < 1200) begin
          @(negedge clk);
          guard++;
          if (ov4 === 1'b1 && xq.size() > 0) begin
            xx = 128'(xq.pop_front());
            a  = aq.pop_front();
            rr = 128'(root4);
            mm = 128'(rem4);
            n_tests++;
            if (!(rr * rr <= xx && xx < (rr + 1) * (rr + 1))) begin
              n_fail++; $display("FAIL stream_root x=%0h: got %0d", xx, rr);
            end
            n_tests++;
            if (mm !== xx - rr * rr) begin
              n_fail++; $display("FAIL stream_rem x=%0h: got %0d required %0d", xx, mm, xx - rr * rr);
            end
            n_tests++;
            if (ot4 !== 16'(got)) begin
              n_fail++; $display("FAIL stream_tag: got %0d required %0d", ot4, got);
            end
            n_tests++;
            if (cyc !== a + 4) begin
              n_fail++; $display("FAIL stream_latency: got %0d required 4", cyc - a);
            end
            got++;
          end
        end
        n_tests++;
        if (got !== 1000) begin n_fail++; $display("FAIL stream_count: got %0d required 1000", got); end
      end
    join
  endtask

  task automatic test_backpressure();
    int idx, exp_i;
    logic [15:0] sr; logic [16:0] sm; logic [7:0] st;
    bit held;
    idx = 0; exp_i = 0; held = 1'b0; sr = '0; sm = '0; st = '0;
    or1 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ov1 === 1'b1) begin
        if (held) begin
          n_tests++;
          if ({root1, rem1, ot1} !== {sr, sm, st}) begin
            n_fail++; $display("FAIL bp_stall_stable: got %0h/%0h/%0h required %0h/%0h/%0h", root1, rem1, ot1, sr, sm, st);
          end
        end
        held = 1'b1; sr = root1; sm = rem1; st = ot1;
      end
      v1 = 1'b1; x1 = 32'(idx * idx + idx); t1 = 8'(idx);
      #1;
      if (r1 === 1'b1) idx++;
    end
    n_tests++;
    if (idx !== 16) begin n_fail++; $display("FAIL bp_accepts: got %0d required 16", idx); end
    n_tests++;
    if (r1 !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full: got %b required 0", r1); end
    n_tests++;
    if (st !== 8'd0 || !held) begin n_fail++; $display("FAIL bp_head_tag: got %0d required 0", st); end
    for (int c = 0; c < 37; c++) begin
      @(negedge clk);
      if (c < 36) begin
        n_tests++;
        if (ov1 !== 1'b1 || root1 !== 16'(exp_i) || rem1 !== 17'(exp_i) || ot1 !== 8'(exp_i)) begin
          n_fail++;
          $display("FAIL bp_drain[%0d]: valid=%b root=%0d rem=%0d tag=%0d required 1/%0d/%0d/%0d",
                   c, ov1, root1, rem1, ot1, exp_i, exp_i, exp_i);
        end
        exp_i++;
      end else begin
        n_tests++;
        if (ov1 !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b required 0", ov1); end
      end
      or1 = 1'b1;
      v1 = (idx < 36); x1 = 32'(idx * idx + idx); t1 = 8'(idx);
      #1;
      if (c == 0) begin
        n_tests++;
        if (r1 !== 1'b1) begin n_fail++; $display("FAIL bp_passthrough_ready: got %b required 1", r1); end
      end
      if (v1 && r1) idx++;
    end
    v1 = 1'b0;
  endtask

  task automatic test_bubble();
    logic [7:0] exp_t [$];
    int acc, got;
    acc = 0; got = 0;
    or1 = 1'b0;
    @(negedge clk);
    v1 = 1'b1; x1 = 32'd49; t1 = 8'hA0;
    #1;
    n_tests++;
    if (r1 !== 1'b1) begin n_fail++; $display("FAIL bubble_accept_a: got %b required 1", r1); end
    @(negedge clk);
    v1 = 1'b0;
    repeat (4) @(negedge clk);
    v1 = 1'b1; x1 = 32'd50; t1 = 8'hB0;
    #1;
    n_tests++;
    if (r1 !== 1'b1) begin n_fail++; $display("FAIL bubble_accept_b: got %b required 1", r1); end
    @(negedge clk);
    v1 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_tests++;
      if (r1 !== 1'b1) begin n_fail++; $display("FAIL bubble_in_ready[%0d]: got %b required 1", c, r1); end
    end
    n_tests++;
    if (ov1 !== 1'b1 || ot1 !== 8'hA0) begin n_fail++; $display("FAIL bubble_head: valid=%b tag=%0h required 1/a0", ov1, ot1); end
    exp_t.push_back(8'hA0);
    exp_t.push_back(8'hB0);
    // Remaining capacity reveals the occupancy: two held, fourteen free.
    for (int c = 0; c < 20; c++) begin
      v1 = 1'b1; x1 = 32'(c); t1 = 8'(8'hC0 + acc);
      #1;
      if (r1 === 1'b1) begin exp_t.push_back(t1); acc++; end
      @(negedge clk);
    end
    v1 = 1'b0;
    n_tests++;
    if (acc !== 14) begin n_fail++; $display("FAIL bubble_occupancy: free slots %0d required 14", acc); end
    or1 = 1'b1;
    for (int c = 0; c < 20 && got < 16; c++) begin
      if (ov1 === 1'b1) begin
        n_tests++;
        if (exp_t.size() == 0 || ot1 !== exp_t[0]) begin
          n_fail++; $display("FAIL bubble_order[%0d]: tag=%0h required %0h", got, ot1, exp_t.size() ? exp_t[0] : 8'h00);
        end
        if (got == 1) begin
          n_tests++;
          if (c !== 1 || root1 !== 16'd7 || rem1 !== 17'd1) begin
            n_fail++; $display("FAIL bubble_b_adjacent: cycle=%0d root=%0d rem=%0d required 1/7/1", c, root1, rem1);
          end
        end
        if (exp_t.size() > 0) void'(exp_t.pop_front());
        got++;
      end
      @(negedge clk);
    end
    n_tests++;
    if (got !== 16) begin n_fail++; $display("FAIL bubble_drain_count: got %0d required 16", got); end
  endtask

  task automatic test_reset_mid();
    int k, stale;
    stale = 0;
    or1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v1 = 1'b1; x1 = 32'(1000 + i); t1 = 8'(8'h30 + i);
    end
    @(negedge clk);
    rst = 1'b1; v1 = 1'b1; x1 = 32'd9; t1 = 8'hEE;
    @(negedge clk);
    rst = 1'b0; v1 = 1'b0;
    n_tests++;
    if (ov1 !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b required 0", ov1); end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ov1 !== 1'b0) stale++;
    end
    n_tests++;
    if (stale !== 0) begin n_fail++; $display("FAIL rstmid_stale: %0d valid cycles required 0", stale); end
    v1 = 1'b1; x1 = 32'd100; t1 = 8'h55;
    #1;
    n_tests++;
    if (r1 !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b required 1", r1); end
    @(negedge clk);
    v1 = 1'b0;
    k = 1;
    while (ov1 !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    n_tests++;
    if (k !== 16) begin n_fail++; $display("FAIL rstmid_latency: got %0d required 16", k); end
    n_tests++;
    if (root1 !== 16'd10 || rem1 !== 17'd0 || ot1 !== 8'h55) begin
      n_fail++; $display("FAIL rstmid_result: root=%0d rem=%0d tag=%0h required 10/0/55", root1, rem1, ot1);
    end
  endtask

  task automatic test_param_sweep();
    int c;
    c = 0;
    sw_start = 1'b1;
    while (sw_left != 0 && c < 67000) begin @(negedge clk); c++; end
    n_tests++;
    if (sw_left !== 0) begin n_fail++; $display("FAIL sweep_timeout: %0d configs unfinished required 0", sw_left); end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_stream();
    test_backpressure();
    test_bubble();
    test_reset_mid();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/isqrt_pipe.md
# isqrt_pipe

- Fully pipelined unsigned integer square root with per-stage valid/ready flow control, tag pass-through and remainder output.
- Generalised successor of the single registered square-root slice: operand width and slices per register stage are parameters, and the pipeline absorbs downstream backpressure with bubble collapsing.
- Sits between the formula front-end and result consumers of the arithmetic pipeline; accepts one operand per cycle.

## Interface
- `W`, 32: operand width. Must be even and ≥ 2; elaboration error otherwise.
- `S`, 1: combinational sqrt slices per register stage, 1 ≤ S ≤ W/2.
- `TAG_W`, 8: width of the opaque sideband tag, ≥ 1.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand present.
- `in_ready`  out  1  block accepts the operand this cycle.
- `in_x`  in  W  unsigned radicand.
- `in_tag`  in  TAG_W  sideband, returned unchanged with the result.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes the result this cycle.
- `out_root`  out  W/2  floor(sqrt(in_x)).
- `out_rem`  out  W/2+1  in_x − out_root², in range 0..2·out_root.
- `out_tag`  out  TAG_W  tag of that operand.

## Operation
- Number of slices: N_SL = W/2. Number of stages: N = ceil(N_SL/S); the last stage holds N_SL − (N−1)·S slices.
- Slice i (0-based) uses the constant m_i = 1 << (W−2−2i); m is never stored.
- Slice state is (x, y), both W bits. At entry x = in_x and y = 0.
- Slice update: if x ≥ (y | m_i), then x −= (y | m_i) and y = (y >> 1) | m_i; otherwise y = y >> 1.
- After all slices: out_root = y[W/2−1:0] and out_rem = x[W/2:0]. The discarded high bits are provably zero; assert this in simulation.
- Stage k registers vld[k], x, y and tag. The last stage's registers drive the outputs directly; no combinational logic sits after them.
- Stage k loads when `load_k = !vld[k] || adv_{k+1}`:
  - adv_{k+1} is the load condition of stage k+1.
  - For the last stage it is out_ready.
  - Stage 0 uses in_valid as its upstream valid; in_ready = load_0.
- When load_k is true, vld[k] ← upstream valid. Data registers are written only when load_k and upstream valid are both true; otherwise they hold.
- Bubble collapsing: an empty stage accepts even while the stage after it is stalled. The ready chain is combinational, with depth N.
- Order is strictly preserved; nothing is dropped or duplicated.
- Capacity is N results in flight.

## Timing
- Reset:
  - all vld ← 0, so out_valid = 0.
  - in_ready = 1 in the cycle after rst is seen high.
  - Data and tag registers are not reset; out_root, out_rem and out_tag are unspecified while out_valid = 0.
- Latency: an operand accepted at edge t is presented with out_valid = 1 after edge t+N−1, i.e. N cycles when out_ready is held high.
  - W=32, S=1 → 16 cycles.
  - W=32, S=4 → 4 cycles.
- Throughput: one result per cycle when out_ready = 1.
- Stall: out_valid/out_root/out_rem/out_tag are stable while out_valid = 1 and out_ready = 0.
- Full pipe (all vld = 1) with out_ready = 0 gives in_ready = 0. Same-cycle out_ready = 1 makes in_ready = 1 (pass-through ready, no dead cycle).
- Reset mid-operation clears all in-flight results. No stale result appears afterwards, and the reset cycle is not treated as an accept.
- in_ready may depend combinationally on out_ready; in_valid must not depend on in_ready.

## Structure
- Package `isqrt_pkg`:
  - `isqrt_n_stages(W, S)` function.
  - `isqrt_m(W, i)` function.
  - Width localparams for root and remainder.
- Sub-module `isqrt_pipe_stage`: parameters W, TAG_W, first slice index, slice count. It holds the combinational slice chain plus the stage registers and the valid/load logic.
- `isqrt_pipe` generates N instances and wires the ready chain.

## Test plan
- Edge values, W=32, S=1: x=0 → root 0, rem 0; x=16 → 4, 0; x=17 → 4, 1; x=0xFFFF_FFFF → 65535, 131070. out_valid rises exactly 16 cycles after each accept.
- Streaming, W=32, S=4: 1000 back-to-back random operands with distinct tags and out_ready = 1. Required: one result per cycle, 4-cycle latency, results match the reference model and tags come back in order.
- Backpressure: stream operands with out_ready = 0 for 20 cycles, W=32, S=1. Required: in_ready falls after exactly 16 accepts, outputs stay stable, and releasing out_ready drains all 16 in order, then resumes at one per cycle.
- Bubble collapse: accept A, wait 5 cycles, accept B, hold out_ready = 0. Required: B advances until it sits directly behind A; pipe occupancy reads 2 and in_ready stays 1.
- Reset mid-flight: assert rst for 1 cycle with 10 items in flight. Required: out_valid = 0 from the next cycle, no item from before reset ever appears, and the first operand after reset completes correctly.
- Parameter sweep: W ∈ {2, 8, 16, 32, 64}, S ∈ {1, 3, W/2}, exhaustive for W ≤ 16 and random otherwise. Required: root² ≤ x < (root+1)² and rem = x − root², with latency = ceil((W/2)/S).
